// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC accelerator datapath.
package ecc_pkg;

  localparam int ECC_WIDTH = 64;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SQ,
    SQ_WAIT,
    MUL,
    MUL_WAIT,
    DONE
  } modexp_state_e;

endpackage

// File: rtl/mod_exp_sequencer.sv
// Left-to-right square-and-multiply sequencer for base^exp mod p.
// Drives a shared external modular multiplier through a start/finish handshake.
module mod_exp_sequencer
  import ecc_pkg::*;
#(
  parameter int WIDTH = ECC_WIDTH,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] base_i,
  input  logic [WIDTH-1:0] exp_i,
  input  logic [WIDTH-1:0] p_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] mul_a_o,
  output logic [WIDTH-1:0] mul_b_o,
  output logic [WIDTH-1:0] mul_p_o,
  output logic             mul_start_o,
  input  logic             mul_finish_i,
  input  logic [WIDTH-1:0] mul_result_i
);

  modexp_state_e    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] base_q, exp_q, p_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] mul_a_q, mul_b_q;
  logic             mul_start_q;
  logic             launch_mul;

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SCAN;
          idx_d   = IDX_W'(WIDTH - 1);
        end
      end
      SCAN: begin
        if (exp_q[idx_q]) begin
          acc_d = base_q;
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQ;
          end
        end else if (idx_q == '0) begin
          // exp == 0: x^0 = 1, which reduces to 0 when p == 1
          acc_d   = (p_q == WIDTH'(1)) ? '0 : WIDTH'(1);
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      SQ:  state_d = SQ_WAIT;
      SQ_WAIT: begin
        if (mul_finish_i) begin
          acc_d = mul_result_i;
          if (exp_q[idx_q]) begin
            state_d = MUL;
          end else if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQ;
          end
        end
      end
      MUL: state_d = MUL_WAIT;
      MUL_WAIT: begin
        if (mul_finish_i) begin
          acc_d = mul_result_i;
          if (idx_q == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are loaded on entry to SQ/MUL so the start pulse and the
  // operands appear together in that state's cycle.
  assign launch_mul = (state_d == SQ) || (state_d == MUL);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      base_q      <= '0;
      exp_q       <= '0;
      p_q         <= '0;
      result_q    <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      mul_start_q <= launch_mul;
      if (state_q == IDLE && start_i) begin
        base_q <= base_i;
        exp_q  <= exp_i;
        p_q    <= p_i;
      end
      if (launch_mul) begin
        mul_a_q <= acc_d;
        mul_b_q <= (state_d == SQ) ? acc_d : base_q;
      end
      if (state_d == DONE) begin
        result_q <= acc_d;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign result_o    = result_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign mul_p_o     = p_q;
  assign mul_start_o = mul_start_q;

endmodule

// File: tb/tb_mod_exp_sequencer.sv
// Self-checking bench for mod_exp_sequencer with a behavioural multiplier of
// programmable latency and a result scoreboard.
module tb_mod_exp_sequencer;
  import ecc_pkg::*;

  localparam int W = ECC_WIDTH;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         start_i = 1'b0;
  logic [W-1:0] base_i = '0, exp_i = '0, p_i = '0;
  logic         busy_o, done_o, mul_start_o;
  logic [W-1:0] result_o, mul_a_o, mul_b_o, mul_p_o;
  logic         mul_finish_i = 1'b0;
  logic [W-1:0] mul_result_i = '0;

  mod_exp_sequencer #(.WIDTH(W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .base_i       (base_i),
    .exp_i        (exp_i),
    .p_i          (p_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .result_o     (result_o),
    .mul_a_o      (mul_a_o),
    .mul_b_o      (mul_b_o),
    .mul_p_o      (mul_p_o),
    .mul_start_o  (mul_start_o),
    .mul_finish_i (mul_finish_i),
    .mul_result_i (mul_result_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0] base;
    logic [W-1:0] exp;
    logic [W-1:0] p;
    int           lat;
    logic [W-1:0] res;
    int           starts;
  } vec_t;

  vec_t         vecs[8];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] sb_q[$];

  int           lat = 1;
  int           mul_starts = 0;
  int           pend = 0;
  logic         inject = 1'b0;
  logic [W-1:0] cap_a = '0, cap_b = '0, cap_p = '0, cur_p = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, b, p);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return (p == '0) ? '0 : W'(prod % {{W{1'b0}}, p});
  endfunction

  // Behavioural multiplier: finish arrives lat cycles after the start pulse.
  always @(negedge clk_i) begin
    mul_finish_i = 1'b0;
    if (pend > 0) begin
      if (rst_ni && busy_o) begin
        check("mul_a_stable", mul_a_o, cap_a);
        check("mul_b_stable", mul_b_o, cap_b);
        check("mul_p_stable", mul_p_o, cur_p);
      end
      pend--;
      if (pend == 0) begin
        mul_finish_i = 1'b1;
        mul_result_i = mulmod(cap_a, cap_b, cap_p);
      end
    end
    if (inject) begin
      mul_finish_i = 1'b1;
      mul_result_i = 64'h1234;
    end
    if (mul_start_o) begin
      cap_a = mul_a_o;
      cap_b = mul_b_o;
      cap_p = mul_p_o;
      pend  = lat;
      mul_starts++;
      check("mul_p_at_start", mul_p_o, cur_p);
    end
  end

  task automatic run_vec(input vec_t v, input bit intrude);
    int k, n1, exp_lat, cyc, s0;
    bit seen;
    k = 0;
    n1 = 0;
    seen = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (v.exp[i]) begin
        if (!seen) begin k = i; seen = 1; end
        else n1++;
      end
    end
    exp_lat = 1 + (W - k) + (k + n1) * (v.lat + 1) + 1;
    lat   = v.lat;
    cur_p = v.p;
    @(negedge clk_i);
    base_i  = v.base;
    exp_i   = v.exp;
    p_i     = v.p;
    start_i = 1'b1;
    s0      = mul_starts;
    sb_q.push_back(v.res);
    cyc  = 1;
    seen = 0;
    while (!seen && cyc < 4000) begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 2) begin
        start_i = 1'b0;
        base_i  = {$urandom, $urandom};
        exp_i   = {$urandom, $urandom};
        p_i     = {$urandom, $urandom};
      end
      if (intrude && cyc == 6) begin
        start_i = 1'b1;
        base_i  = 64'd2;
        exp_i   = 64'd5;
        p_i     = 64'd7;
      end
      if (intrude && cyc == 7) start_i = 1'b0;
      if (done_o) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: no done_o within %0d cycles", cyc);
      void'(sb_q.pop_front());
    end else begin
      check("result", result_o, sb_q.pop_front());
      check("latency", W'(cyc), W'(exp_lat));
      check("mul_starts", W'(mul_starts - s0), W'(v.starts));
      check("busy_at_done", W'(busy_o), W'(1));
      @(negedge clk_i);
      check("done_one_cycle", W'(done_o), W'(0));
      check("idle_after_done", W'(busy_o), W'(0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held;
    int           s0, n;
    bit           bad;

    vecs[0] = '{64'd5, 64'd3,  64'd23, 3, 64'd10, 2};
    vecs[1] = '{64'd5, 64'd11, 64'd23, 1, 64'd22, 5};
    vecs[2] = '{64'd3, 64'd5,  64'd7,  2, 64'd5,  3};
    vecs[3] = '{64'd3, 64'd0,  64'd7,  2, 64'd1,  0};
    vecs[4] = '{64'd0, 64'd0,  64'd1,  2, 64'd0,  0};
    vecs[5] = '{64'd2, 64'd63, 64'h1FFF_FFFF_FFFF_FFFF, 7, 64'd4, 10};
    vecs[6] = '{64'd7, 64'd21, 64'd23, 2, 64'd10, 6};
    vecs[7] = '{64'd9, 64'd1,  64'd23, 1, 64'd9,  0};

    repeat (3) @(negedge clk_i);
    check("reset_busy", W'(busy_o), W'(0));
    check("reset_done", W'(done_o), W'(0));
    check("reset_result", result_o, '0);
    check("reset_mul_start", W'(mul_start_o), W'(0));
    check("reset_mul_p", mul_p_o, '0);
    rst_ni = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], 1'b0);

    // second start while busy must be ignored
    run_vec(vecs[0], 1'b1);

    // spurious finish in IDLE
    held = result_o;
    @(posedge clk_i);
    inject = 1'b1;
    @(posedge clk_i);
    inject = 1'b0;
    bad = 0;
    repeat (4) begin
      @(negedge clk_i);
      if (busy_o || done_o || result_o !== held) bad = 1;
    end
    check("spurious_finish_idle", W'(bad), W'(0));

    // reset during MUL_WAIT
    lat   = 7;
    cur_p = 64'd23;
    @(negedge clk_i);
    base_i  = 64'd5;
    exp_i   = 64'd3;
    p_i     = 64'd23;
    start_i = 1'b1;
    s0      = mul_starts;
    @(negedge clk_i);
    start_i = 1'b0;
    n = 0;
    while (mul_starts < s0 + 2 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    check("reached_mul_wait", W'(mul_starts - s0), W'(2));
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("abort_busy", W'(busy_o), W'(0));
    check("abort_done", W'(done_o), W'(0));
    check("abort_result", result_o, '0);
    check("abort_mul_start", W'(mul_start_o), W'(0));
    check("abort_mul_a", mul_a_o, '0);
    check("abort_mul_b", mul_b_o, '0);
    check("abort_mul_p", mul_p_o, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk_i);
      if (busy_o || done_o || mul_start_o) bad = 1;
    end
    check("late_finish_ignored", W'(bad), W'(0));
    run_vec(vecs[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
